// File: rtl/mips_md_pkg.sv
// Shared multiply/divide definitions: op encodings, FSM states, width and sign helpers.
// Combinational helpers only; no latency.
// No flow control here; the controller decodes with these same constants.
package mips_md_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CALC  = 2'b01,
        FIXUP = 2'b10
    } md_state_e;

    // Magnitude of an operand; unsigned ops pass straight through.
    // 0x80000000 maps to itself, which is its correct unsigned magnitude.
    function automatic logic [MD_WIDTH-1:0] abs_val(input logic [MD_WIDTH-1:0] x,
                                                    input logic            is_signed);
        return (is_signed && x[MD_WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [MD_WIDTH-1:0] negate_w(input logic [MD_WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    function automatic logic [2*MD_WIDTH-1:0] negate_dw(input logic [2*MD_WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Controller <-> multiply/divide unit bundle: launch, MTHI/MTLO writes, HI/LO readback.
// Wires only; no latency.
// Controller stalls on busy; start/hi_we/lo_we are ignored while busy is high.
interface mul_div_unit_if #(parameter int WIDTH = mips_md_pkg::MD_WIDTH);
    import mips_md_pkg::*;

    logic             start;
    md_op_e           op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, wr_data,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, wr_data,
        output hi, lo, busy, done
    );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair, plus MTHI/MTLO writes.
// Latency: fixed WIDTH+1 cycles from start acceptance to HI/LO update (33 at WIDTH=32).
// Backpressure: busy stalls the controller; start and MT writes are dropped while busy.
module mul_div_unit
    import mips_md_pkg::*;
#(
    // Sign helpers are sized by MD_WIDTH; change the package constant to resize.
    parameter int WIDTH = MD_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  md
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      count_q;
    md_op_e             op_q;
    logic [WIDTH-1:0]   mag_q;      // multiplicand (mul) or divisor (div) magnitude
    logic [2*WIDTH-1:0] acc_q;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic               neg_res_q;  // negate product / quotient at fixup
    logic               neg_rem_q;  // negate remainder at fixup
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    logic               in_signed, in_div, rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_abs, rt_abs;
    logic               is_div_q;
    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic               div_ok;
    logic [2*WIDTH-1:0] acc_next, prod;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    // Decode the incoming op and form operand magnitudes and signs.
    always_comb begin
        in_signed = (md.op == MD_MULT) || (md.op == MD_DIV);
        in_div    = (md.op == MD_DIV) || (md.op == MD_DIVU);
        rs_neg    = in_signed && md.rs_data[WIDTH-1];
        rt_neg    = in_signed && md.rt_data[WIDTH-1];
        rs_abs    = abs_val(md.rs_data, in_signed);
        rt_abs    = abs_val(md.rt_data, in_signed);
    end

    // One shift-add or restoring-divide step; a zero divisor always "fits",
    // giving an all-ones quotient and the dividend magnitude as remainder.
    always_comb begin
        is_div_q  = (op_q == MD_DIV) || (op_q == MD_DIVU);
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, mag_q};
        div_ok    = ~div_trial[WIDTH];
        if (is_div_q) begin
            acc_next = {(div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ok};
        end else begin
            acc_next = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
        prod   = neg_res_q ? negate_dw(acc_q) : acc_q;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div_q) begin
            fix_lo = neg_res_q ? negate_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
            fix_hi = neg_rem_q ? negate_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        end
    end

    // Next-state logic: IDLE -> CALC for WIDTH steps -> FIXUP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (md.start) state_d = CALC;
            CALC:    if (count_q == CW'(WIDTH - 1)) state_d = FIXUP;
            FIXUP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath: operand capture, iteration, result write-back and MT writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            op_q      <= MD_MULT;
            mag_q     <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (md.hi_we) hi_q <= md.wr_data;
                    if (md.lo_we) lo_q <= md.wr_data;
                    if (md.start) begin
                        op_q      <= md.op;
                        count_q   <= '0;
                        mag_q     <= in_div ? rt_abs : rs_abs;
                        acc_q     <= {{WIDTH{1'b0}}, (in_div ? rs_abs : rt_abs)};
                        // Divide-by-zero keeps the quotient unnegated (all ones).
                        neg_res_q <= (rs_neg ^ rt_neg) && !(in_div && (md.rt_data == '0));
                        neg_rem_q <= rs_neg;
                    end
                end
                CALC: begin
                    acc_q   <= acc_next;
                    count_q <= count_q + 1'b1;
                end
                FIXUP: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    count_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
    assign md.busy = (state_q != IDLE);
    assign md.done = done_q;

endmodule
